// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller
// Purpose  : Multi-cycle MIPS control FSM. It sequences fetch, decode,
//            execute, memory and write-back so that one ALU and one unified
//            memory port are shared. It stalls on the memory ready handshake.
// Options  : PERF_CNT_EN - adds the cycle_cnt/instr_cnt performance counters
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] ALUop,
    output logic [3:0] state_out,
    output logic       illegal
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
`endif
);

    // Opcodes that the controller understands
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    // State encodings are visible on state_out, so the values are fixed
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    state_t r_state;
    state_t w_next_state;
    logic   r_illegal;
    logic   w_illegal_op;

    // A zero or negative counter width cannot be built
    if (CNT_W < 1) begin : g_cnt_w_check
        $error("multicycle_controller: CNT_W must be at least 1");
    end

    // Next-state selection; unused encodings fall back to FETCH
    always_comb begin
        w_next_state = S_FETCH;
        w_illegal_op = 1'b0;
        case (r_state)
            S_FETCH:  w_next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    c_OP_RTYPE:       w_next_state = S_EXEC;
                    c_OP_LW, c_OP_SW: w_next_state = S_MEMADR;
                    c_OP_BEQ:         w_next_state = S_BRANCH;
                    c_OP_ADDI:        w_next_state = S_ADDIEX;
                    c_OP_J:           w_next_state = S_JUMP;
                    default: begin
                        // Unsupported opcode retires as a NOP; PC already advanced
                        w_next_state = S_FETCH;
                        w_illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: w_next_state = (opcode == c_OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next_state = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  w_next_state = S_FETCH;
            S_MEMWR:  w_next_state = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   w_next_state = S_ALUWB;
            S_ALUWB:  w_next_state = S_FETCH;
            S_BRANCH: w_next_state = S_FETCH;
            S_ADDIEX: w_next_state = S_ADDIWB;
            S_ADDIWB: w_next_state = S_FETCH;
            S_JUMP:   w_next_state = S_FETCH;
            default:  w_next_state = S_FETCH;
        endcase
    end

    // State register and sticky illegal-opcode flag
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_illegal_op) begin
                r_illegal <= 1'b1;
            end
        end
    end

    // Datapath strobes decoded from state; reset masks every strobe so an
    // abandoned instruction can never write memory or the register file
    always_comb begin
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        ALUop      = 2'b00;
        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    // Branch target computed speculatively into ALUOut
                    alu_src_b = 2'b11;
                end
                S_MEMADR, S_ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                S_MEMWB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                end
                S_MEMWR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    ALUop     = 2'b10;
                end
                S_ALUWB: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    ALUop     = 2'b01;
                    pc_src    = 2'b01;
                    pc_write  = zero;
                end
                S_ADDIWB: begin
                    reg_write = 1'b1;
                end
                S_JUMP: begin
                    pc_src   = 2'b10;
                    pc_write = 1'b1;
                end
                default: begin
                    pc_write = 1'b0;
                end
            endcase
        end
    end

    assign state_out = r_state;
    assign illegal   = r_illegal;

`ifdef PERF_CNT_EN
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instr_cnt;

    // Cycle and retired-instruction counters; both wrap naturally
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + c_CNT_ONE;
            if ((r_state != S_FETCH) && (w_next_state == S_FETCH)) begin
                r_instr_cnt <= r_instr_cnt + c_CNT_ONE;
            end
        end
    end

    assign cycle_cnt = r_cycle_cnt;
    assign instr_cnt = r_instr_cnt;
`endif

endmodule
`default_nettype wire
